// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types and constants for the seven-segment scanner
package seg_scan_pkg;

    localparam int NUM_DIGITS       = 8;
    localparam int DIGITS_PER_GROUP = 4;

    // Digit-to-source mapping: left group feeds digits 0-3, right group 4-7
    localparam int LEFT_FIRST  = 0;
    localparam int RIGHT_FIRST = LEFT_FIRST + DIGITS_PER_GROUP;

    typedef logic [2:0]            digit_idx_t;
    typedef logic [7:0]            seg_pat_t;
    typedef logic [NUM_DIGITS-1:0] dig_mask_t;

    // Dark until the first slot boundary after reset, scanning forever after
    typedef enum logic {
        ST_DARK = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    localparam digit_idx_t LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

    function automatic dig_mask_t digit_onehot(input digit_idx_t i);
        return dig_mask_t'(1) << i;
    endfunction

endpackage

// File: rtl/seg_scan_if.sv
// rtl/seg_scan_if.sv - pattern inputs and display outputs of the scanner
interface seg_scan_if;
    import seg_scan_pkg::*;

    seg_pat_t  l_out0;
    seg_pat_t  l_out1;
    seg_pat_t  l_out2;
    seg_pat_t  l_out3;
    seg_pat_t  r_out0;
    seg_pat_t  r_out1;
    seg_pat_t  r_out2;
    seg_pat_t  r_out3;
    logic      freeze;
    seg_pat_t  seg;
    dig_mask_t dig_en;
    logic      frame_tick;

    // Pattern source / display consumer side
    modport master (
        output l_out0, l_out1, l_out2, l_out3,
        output r_out0, r_out1, r_out2, r_out3,
        output freeze,
        input  seg, dig_en, frame_tick
    );

    // Scanner side
    modport slave (
        input  l_out0, l_out1, l_out2, l_out3,
        input  r_out0, r_out1, r_out2, r_out3,
        input  freeze,
        output seg, dig_en, frame_tick
    );

endinterface

// File: rtl/seg_scan_prescaler.sv
// rtl/seg_scan_prescaler.sv - digit slot counter, resets to terminal count
module seg_scan_prescaler #(
    parameter int PRESCALE = 50000,
    parameter int CW       = $clog2(PRESCALE)
) (
    input  logic          clock,
    input  logic          reset,
    output logic          tick,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] TERMINAL = CW'(PRESCALE - 1);

    // Starting at terminal count makes the first edge after reset a slot boundary
    assign tick = (cnt == TERMINAL);

    // Free-running modulo-PRESCALE count
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= TERMINAL;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - eight-digit multiplexed segment scanner; optional blanking via SEG_SCAN_BLANK_EN
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 16
) (
    input  logic      clock,
    input  logic      reset,
    seg_scan_if.slave bus
);

    localparam int CW = $clog2(PRESCALE);

    logic          tick;
    logic [CW-1:0] cnt;
    logic          frame_start;
    logic          blank_zone;

    digit_idx_t    idx;
    logic          frame_tick_q;
    scan_state_t   state;
    scan_state_t   state_next;
    seg_pat_t      shadow [NUM_DIGITS];
    seg_pat_t      src    [NUM_DIGITS];
    seg_pat_t      seg_d;
    dig_mask_t     dig_en_d;

    seg_scan_prescaler #(
        .PRESCALE (PRESCALE),
        .CW       (CW)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .tick  (tick),
        .cnt   (cnt)
    );

    assign src[LEFT_FIRST + 0]  = bus.l_out0;
    assign src[LEFT_FIRST + 1]  = bus.l_out1;
    assign src[LEFT_FIRST + 2]  = bus.l_out2;
    assign src[LEFT_FIRST + 3]  = bus.l_out3;
    assign src[RIGHT_FIRST + 0] = bus.r_out0;
    assign src[RIGHT_FIRST + 1] = bus.r_out1;
    assign src[RIGHT_FIRST + 2] = bus.r_out2;
    assign src[RIGHT_FIRST + 3] = bus.r_out3;

    // A frame begins when the last digit's slot expires
    assign frame_start = tick && (idx == LAST_DIGIT);

`ifdef SEG_SCAN_BLANK_EN
    localparam logic [CW-1:0] BLANK_START = CW'(PRESCALE - BLANK);
    assign blank_zone = (cnt >= BLANK_START);
`else
    // Slot position and blank length only matter when blanking is built in
    logic unused_blank;
    assign unused_blank = ^{cnt, BLANK[0]};
    assign blank_zone   = 1'b0;
`endif

    // Digit index advances once per slot and the frame pulse is registered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx          <= LAST_DIGIT;
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= frame_start;
            if (tick) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Shadows capture all eight patterns together so no digit tears mid-frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= '0;
            end
        end else if (frame_start && !bus.freeze) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= src[i];
            end
        end
    end

    // Scan state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_DARK;
        end else begin
            state <= state_next;
        end
    end

    // Next state and display drive; dark until the first slot boundary
    always_comb begin
        state_next = state;
        seg_d      = '0;
        dig_en_d   = '0;
        if (tick) begin
            state_next = ST_SCAN;
        end
        if ((state == ST_SCAN) && !blank_zone) begin
            seg_d    = shadow[idx];
            dig_en_d = digit_onehot(idx);
        end
    end

    assign bus.seg        = seg_d;
    assign bus.dig_en     = dig_en_d;
    assign bus.frame_tick = frame_tick_q;

endmodule
